iis_clk_ctrl: RTL

//   Master-mode I2S timing controller. Generates bclk/lrclk from clk_100m for the I2S receive

---
 rtl/iis_pkg.sv | 19 +
 rtl/iis_bclk_div.sv | 47 ++++
 rtl/iis_clk_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/iis_pkg.sv
// Shared I2S definitions used by the clock controller and the sample reader.
//   iis_state_e      : one-hot sequencing states of the clock controller
//   IIS_SLOT_BITS    : bclk periods per channel slot
//   IIS_DATA_BITS    : significant audio bits per slot (MSB first)
//   IIS_MIN_HALF_DIV : smallest bclk half-period, in clk_100m cycles
package iis_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_RUN   = 3'b010,
    ST_DRAIN = 3'b100
  } iis_state_e;

  localparam int IIS_SLOT_BITS    = 32;
  localparam int IIS_DATA_BITS    = 24;
  // Below 2 the reader's single-cycle edge detector would miss bclk edges.
  localparam int IIS_MIN_HALF_DIV = 2;

endpackage

// File: rtl/iis_bclk_div.sv
// Bit-clock divider: toggles bclk every `half` clk_100m cycles while enabled.
//   clk_100m    in   system clock
//   rst_n       in   asynchronous active-low reset
//   en          in   count and toggle while high, hold while low
//   clr         in   restart the divider: counter to 0, bclk low
//   half        in   clk_100m cycles per bclk half-period (>= 2)
//   bclk        out  registered bit clock
//   fall_pulse  out  high in the cycle whose clock edge drives bclk 1->0, so
//                    the caller can update bclk-aligned state on that same edge
module iis_bclk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk_100m,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] half,
  output logic             bclk,
  output logic             fall_pulse
);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_bclk;
  logic             w_wrap;

  assign w_wrap     = en && (r_div_cnt == (half - DIV_W'(1)));
  assign fall_pulse = w_wrap && r_bclk;
  assign bclk       = r_bclk;

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
    end else if (clr) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
    end else if (en) begin
      if (w_wrap) begin
        r_div_cnt <= '0;
        r_bclk    <= ~r_bclk;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/iis_clk_ctrl.sv
// Master-mode I2S timing controller. Produces bclk/lrclk for the codec and the
// I2S sample reader, and sequences capture with start/stop commands. A stop
// always lets the current stereo frame finish before clocks halt.
//   clk_100m     in   system clock
//   rst_n        in   asynchronous active-low reset
//   start_i      in   one-cycle start request (accepted only in IDLE)
//   stop_i       in   one-cycle graceful stop request (end of frame)
//   half_div_i   in   bclk half-period in clk_100m cycles, latched on start
//   bclk         out  I2S bit clock
//   lrclk        out  word select, 0 = left slot, 1 = right slot
//   busy         out  high in RUN or DRAIN
//   frame_start  out  one-cycle pulse with every lrclk 1->0 edge
//   frame_cnt    out  completed frames since last start, wraps
//   o_state      out  one-hot FSM state for observation
// Handshake: start_i/stop_i are single-cycle strobes sampled on the rising
// clk_100m edge; there is no backpressure, a strobe the current state does
// not act on is dropped, never queued.
module iis_clk_ctrl
  import iis_pkg::*;
#(
  parameter int SLOT_BITS = IIS_SLOT_BITS,
  parameter int DIV_W     = 8,
  parameter int FCNT_W    = 16
) (
  input  logic              clk_100m,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [DIV_W-1:0]  half_div_i,
  output logic              bclk,
  output logic              lrclk,
  output logic              busy,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic [2:0]        o_state
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam logic [BIT_W-1:0] LAST_LEFT = BIT_W'(SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(FRAME_BITS - 1);
  localparam logic [DIV_W-1:0] MIN_HALF  = DIV_W'(IIS_MIN_HALF_DIV);

  iis_state_e        r_state;
  iis_state_e        w_state_nxt;
  logic              w_start_acc;
  logic              w_fall;
  logic              w_frame_end;
  logic              w_div_en;
  logic [DIV_W-1:0]  w_half_clamped;
  logic [DIV_W-1:0]  r_half;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              r_lrclk;
  logic              r_frame_start;
  logic [FCNT_W-1:0] r_frame_cnt;
  logic              r_busy;

  assign w_div_en       = (r_state != ST_IDLE);
  assign w_half_clamped = (half_div_i < MIN_HALF) ? MIN_HALF : half_div_i;
  assign w_frame_end    = w_fall && (r_bit_cnt == LAST_BIT);

  // The divider is restarted on the accepting edge so the first bclk high
  // phase is a full half-period after lrclk drops.
  iis_bclk_div #(
    .DIV_W (DIV_W)
  ) u_bclk_div (
    .clk_100m   (clk_100m),
    .rst_n      (rst_n),
    .en         (w_div_en),
    .clr        (w_start_acc),
    .half       (r_half),
    .bclk       (bclk),
    .fall_pulse (w_fall)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // start beats a simultaneous stop here
        if (start_i) begin
          w_state_nxt = ST_RUN;
          w_start_acc = 1'b1;
        end
      end
      ST_RUN: begin
        // stop beats a simultaneous start here
        if (stop_i) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_frame_end) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Slot/frame bookkeeping. lrclk only moves on bclk falling edges (or on
  // start), so the codec shifts its MSB one bclk after the word-select change.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_half        <= MIN_HALF;
      r_bit_cnt     <= '0;
      r_lrclk       <= 1'b1;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_frame_start <= 1'b0;
      if (w_start_acc) begin
        r_half        <= w_half_clamped;
        r_bit_cnt     <= '0;
        r_lrclk       <= 1'b0;
        r_frame_start <= 1'b1;
        r_frame_cnt   <= '0;
      end else if (w_fall) begin
        if (r_bit_cnt == LAST_BIT) begin
          r_bit_cnt   <= '0;
          r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
          // In DRAIN lrclk is left high and the clocks park.
          if (r_state == ST_RUN) begin
            r_lrclk       <= 1'b0;
            r_frame_start <= 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + BIT_W'(1);
          if (r_bit_cnt == LAST_LEFT) r_lrclk <= 1'b1;
        end
      end
    end
  end

  assign lrclk       = r_lrclk;
  assign busy        = r_busy;
  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;
  assign o_state     = r_state;

endmodule
